crc8_apb_slave: RTL and testbench

// APB slave front-end for the team CRC8 core (Dallas/Maxim, x^8+x^5+x^4+1, bit-serial LSB-first, init 0x00).

---
 rtl/crc8_apb_slave.sv | 119 +++++++++++
 tb/tb_crc8_apb_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_apb_slave.sv
// APB front-end for the CRC8 core: byte FIFO paced to the core's busy time, CRC readback with clear strobe.
// Optional macro CRC8_APB_SLVERR_EN enables pslverr_o on illegal accesses.
module crc8_apb_slave #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned CRC_BUSY_CYC = 9,
  parameter int unsigned CLR_BUSY_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [7:0]        crc_din_o,
  output logic              crc_valid_o,
  output logic              crc_rd_o,
  input  logic [7:0]        crc_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GAP_MAX = (CRC_BUSY_CYC > CLR_BUSY_CYC) ? CRC_BUSY_CYC : CLR_BUSY_CYC;
  localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap_cnt;

  logic        access;
  logic        addr_ok;
  logic [1:0]  sel;
  logic        bad;
  logic        empty;
  logic        full;
  logic        busy;
  logic        pop;
  logic        push;
  logic        wr_data;
  logic        clr_req;
  logic        clr_ok;
  logic [31:0] status;
  logic        unused_pwdata;

  assign unused_pwdata = ^pwdata_i[31:8];

  // Decode, FIFO flow control and APB response
  always_comb begin
    empty       = (count == '0);
    full        = (count == CNT_W'(FIFO_DEPTH));
    busy        = !empty || (gap_cnt != '0);
    access      = psel_i && penable_i && !rst_i;
    addr_ok     = (paddr_i[ADDR_W-1:4] == '0) && (paddr_i[1:0] == 2'b00);
    sel         = paddr_i[3:2];
    bad         = !addr_ok || (pwrite_i && ((sel == 2'd1) || (sel == 2'd2)));
    pop         = !rst_i && !empty && (gap_cnt == '0);
    wr_data     = access && !bad && pwrite_i && (sel == 2'd0);
    clr_req     = access && !bad &&
                  ((!pwrite_i && (sel == 2'd1)) || (pwrite_i && (sel == 2'd3) && pwdata_i[0]));
    clr_ok      = empty && (gap_cnt == '0);
    push        = wr_data && (!full || pop);
    crc_valid_o = pop;
    crc_rd_o    = clr_req && clr_ok;
    crc_din_o   = (empty || rst_i) ? 8'h00 : mem[rd_ptr];
    status      = {16'h0000, 8'(count), 6'b000000, full, busy};

    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = 32'h0000_0000;
    if (access) begin
      if (wr_data)      pready_o = !full || pop;
      else if (clr_req) pready_o = clr_ok;
      else              pready_o = 1'b1;
    end
`ifdef CRC8_APB_SLVERR_EN
    pslverr_o = access && bad;
`endif
    if (access && pready_o && !pwrite_i && !bad) begin
      case (sel)
        2'd1:    prdata_o = {24'h000000, crc_i};
        2'd2:    prdata_o = status;
        default: prdata_o = 32'h0000_0000;
      endcase
    end
  end

  // Pointers, occupancy and core pacing counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      gap_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop)                  gap_cnt <= GAP_W'(CRC_BUSY_CYC - 1);
      else if (crc_rd_o)        gap_cnt <= GAP_W'(CLR_BUSY_CYC - 1);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Storage needs no reset; occupancy gates every read of it
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pwdata_i[7:0];
  end

endmodule

// File: tb/tb_crc8_apb_slave.sv
// Self-checking bench for crc8_apb_slave with a behavioural CRC8 core and byte-level CRC model.
module tb_crc8_apb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  crc_din;
  logic        crc_valid;
  logic        crc_rd;
  logic [7:0]  crc_core = 8'h00;

`ifdef CRC8_APB_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_rd = 0;
  int n_overlap = 0;
  int vq[$];
  logic [7:0] exp_crc = 8'h00;

  crc8_apb_slave dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .crc_din_o(crc_din), .crc_valid_o(crc_valid),
    .crc_rd_o(crc_rd), .crc_i(crc_core)
  );

  always #5 clk = ~clk;

  // Dallas/Maxim CRC8, reflected polynomial 0x8C, one byte LSB-first
  function automatic logic [7:0] crc8_update(input logic [7:0] c, input logic [7:0] b);
    int v;
    v = int'(c ^ b);
    for (int i = 0; i < 8; i++) v = (v % 2 == 1) ? ((v / 2) ^ 8'h8C) : (v / 2);
    return 8'(v);
  endfunction

  // Core model and strobe monitor
  always @(posedge clk) begin
    cyc++;
    if (rst) crc_core <= 8'h00;
    else if (crc_valid) crc_core <= crc8_update(crc_core, crc_din);
    else if (crc_rd) crc_core <= 8'h00;
    if (!rst) begin
      if (crc_valid) begin n_valid++; vq.push_back(cyc); end
      if (crc_rd) n_rd++;
      if (crc_valid && crc_rd) n_overlap++;
    end
  end

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!pready && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    if (!pready) begin
      checks++; failures++;
      $display("FAIL apb_timeout addr=%h waits=%0d required pready=1", addr, waits);
    end
    rd = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output int waits);
    logic [31:0] rd; logic err;
    apb(1'b1, 8'h00, {$urandom_range(0, 255), 16'h0, b}, rd, err, waits);
    exp_crc = crc8_update(exp_crc, b);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w;
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h04;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pready, pslverr, crc_rd, crc_valid} !== 4'b0 || prdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got rdy/err/rd/vld=%b prdata=%h required 0", {pready, pslverr, crc_rd, crc_valid}, prdata);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rst = 1'b0; n_valid = 0; n_rd = 0;
    apb(1'b0, 8'h08, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got %h required 00000000", rd); end
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_crc got %h required 00000000", rd); end
    checks++;
    if (n_rd !== 1 || n_valid !== 0) begin
      failures++; $display("FAIL reset_strobes got rd=%0d valid=%0d required 1 0", n_rd, n_valid);
    end
    exp_crc = 8'h00;
  endtask

  task automatic test_single();
    logic [31:0] rd; logic err; int w;
    wr_byte(8'h01, w);
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (w < 8) begin failures++; $display("FAIL single_wait got %0d required >=8", w); end
    checks++;
    if (rd !== 32'h5E) begin failures++; $display("FAIL single_crc got %h required 0000005e", rd); end
    exp_crc = 8'h00;
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL single_cleared got %h required 00000000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w; int max_w; int bad_gaps;
    vq.delete(); n_valid = 0; n_overlap = 0; max_w = 0;
    for (int i = 0; i < 9; i++) begin
      wr_byte(8'(8'h31 + i), w);
      if (w > max_w) max_w = w;
    end
    checks++;
    if (max_w == 0) begin failures++; $display("FAIL b2b_full_stall got max_wait=0 required >0"); end
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'hA1) begin failures++; $display("FAIL b2b_crc got %h required 000000a1", rd); end
    exp_crc = 8'h00;
    checks++;
    if (n_valid !== 9) begin failures++; $display("FAIL b2b_valid_count got %0d required 9", n_valid); end
    bad_gaps = 0;
    for (int i = 1; i < vq.size(); i++) if (vq[i] - vq[i-1] != 9) bad_gaps++;
    checks++;
    if (bad_gaps !== 0) begin failures++; $display("FAIL b2b_gaps got %0d gaps !=9 required 0", bad_gaps); end
    checks++;
    if (n_overlap !== 0) begin failures++; $display("FAIL b2b_overlap got %0d required 0", n_overlap); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic err; int w; int n;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) wr_byte(8'($urandom_range(0, 255)), w);
      apb(1'b0, 8'h08, 32'h0, rd, err, w);
      checks++;
      if (rd[0] !== 1'b1) begin failures++; $display("FAIL rand_busy round=%0d got %b required 1", r, rd[0]); end
      apb(1'b0, 8'h04, 32'h0, rd, err, w);
      checks++;
      if (rd !== {24'h0, exp_crc}) begin
        failures++; $display("FAIL rand_crc round=%0d got %h required %h", r, rd, {24'h0, exp_crc});
      end
      exp_crc = 8'h00;
    end
  endtask

  task automatic test_ctrl_clear();
    logic [31:0] rd; logic err; int w;
    wr_byte(8'($urandom_range(0, 255)), w);
    wr_byte(8'($urandom_range(0, 255)), w);
    apb(1'b1, 8'h0C, 32'h1, rd, err, w);
    exp_crc = 8'h00;
    checks++;
    if (w == 0) begin failures++; $display("FAIL ctrl_wait got 0 required >0"); end
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL ctrl_clear got %h required 00000000", rd); end
    wr_byte(8'h9C, w);
    apb(1'b1, 8'h0C, 32'h0, rd, err, w);
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== {24'h0, exp_crc}) begin
      failures++; $display("FAIL ctrl_noop got %h required %h", rd, {24'h0, exp_crc});
    end
    exp_crc = 8'h00;
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic err; int w; int rd0;
    wr_byte(8'h01, w);
    repeat (12) @(negedge clk);
    rd0 = n_rd;
    apb(1'b0, 8'h10, 32'h0, rd, err, w);
    checks++;
    if (err !== EXP_ERR || rd !== 32'h0) begin
      failures++; $display("FAIL err_read_hi got err=%b rd=%h required err=%b rd=0", err, rd, EXP_ERR);
    end
    apb(1'b1, 8'h04, 32'hFF, rd, err, w);
    checks++;
    if (err !== EXP_ERR) begin failures++; $display("FAIL err_write_crc got %b required %b", err, EXP_ERR); end
    apb(1'b0, 8'h05, 32'h0, rd, err, w);
    checks++;
    if (err !== EXP_ERR || rd !== 32'h0) begin
      failures++; $display("FAIL err_misaligned got err=%b rd=%h required err=%b rd=0", err, rd, EXP_ERR);
    end
    checks++;
    if (n_rd !== rd0) begin failures++; $display("FAIL err_no_clear got %0d required %0d", n_rd, rd0); end
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h5E || err !== 1'b0) begin
      failures++; $display("FAIL err_crc_kept got rd=%h err=%b required 0000005e 0", rd, err);
    end
    exp_crc = 8'h00;
  endtask

  task automatic test_abandon();
    logic [31:0] rd; logic err; int w; int rd0;
    wr_byte(8'h5A, w);
    rd0 = n_rd;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pready !== 1'b0) begin failures++; $display("FAIL abandon_stall got %b required 0", pready); end
    psel = 1'b0; penable = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (n_rd !== rd0) begin failures++; $display("FAIL abandon_no_strobe got %0d required %0d", n_rd, rd0); end
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== {24'h0, exp_crc}) begin
      failures++; $display("FAIL abandon_crc got %h required %h", rd, {24'h0, exp_crc});
    end
    exp_crc = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    for (int i = 0; i < 3; i++) wr_byte(8'($urandom_range(0, 255)), w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (crc_valid !== 1'b0 || crc_din !== 8'h00) begin
      failures++; $display("FAIL midrst_outputs got vld=%b din=%h required 0 00", crc_valid, crc_din);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_crc = 8'h00;
    apb(1'b0, 8'h08, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL midrst_status got %h required 00000000", rd); end
    wr_byte(8'h01, w);
    apb(1'b0, 8'h04, 32'h0, rd, err, w);
    checks++;
    if (rd !== 32'h5E) begin failures++; $display("FAIL midrst_crc got %h required 0000005e", rd); end
    exp_crc = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_ctrl_clear();
    test_slverr();
    test_abandon();
    test_reset_mid();
    checks++;
    if (n_overlap !== 0) begin failures++; $display("FAIL final_overlap got %0d required 0", n_overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached required finish");
    $fatal(1, "timeout");
  end

endmodule
